// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, message-locking arbiter sharing one uart_tx
//               serializer between NUM_REQ byte sources, with watchdogs.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 87,
    parameter int HOLD_CLKS    = 1024
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_n,
    input  logic [NUM_REQ-1:0]     i_Req_DV,
    input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
    input  logic [NUM_REQ-1:0]     i_Req_Last,
    output logic [NUM_REQ-1:0]     o_Req_Ack,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_Busy,
    output logic                   o_Err_Timeout,
    output logic                   o_Tx_DV,
    output logic [7:0]             o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done
);

    localparam int c_WDOG    = 12 * CLKS_PER_BIT;
    localparam int c_CNT_MAX = (c_WDOG > HOLD_CLKS) ? c_WDOG : HOLD_CLKS;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = $clog2(NUM_REQ);
    localparam int c_SUM_W   = c_IDX_W + 1;

    localparam logic [c_CNT_W-1:0] c_WDOG_CNT = c_CNT_W'(c_WDOG);
    localparam logic [c_CNT_W-1:0] c_HOLD_CNT = c_CNT_W'(HOLD_CLKS);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(c_CNT_MAX);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_DRAIN     = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    state_t               r_state,   w_state_nxt;
    logic [c_IDX_W-1:0]   r_gidx,    w_gidx_nxt;
    logic [NUM_REQ-1:0]   r_grant,   w_grant_nxt;
    logic [c_IDX_W-1:0]   r_rr,      w_rr_nxt;
    logic [c_CNT_W-1:0]   r_cnt,     w_cnt_nxt;
    logic                 r_last,    w_last_nxt;
    logic [NUM_REQ-1:0]   r_ack,     w_ack_nxt;
    logic                 r_tx_dv,   w_tx_dv_nxt;
    logic [7:0]           r_tx_byte, w_tx_byte_nxt;
    logic                 r_err,     w_err_nxt;
    logic                 r_busy,    w_busy_nxt;

    logic                 w_win_found;
    logic [c_IDX_W-1:0]   w_win_idx;
    logic [c_SUM_W-1:0]   w_sum;
    logic [c_IDX_W-1:0]   w_issue_idx;
    logic [c_IDX_W-1:0]   w_g_next;
    logic [c_CNT_W-1:0]   w_cnt_inc;

    // Scan downward so the candidate closest to the rr pointer is written last.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_sum       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_rr} + c_SUM_W'(i);
            if (w_sum >= c_SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - c_SUM_W'(NUM_REQ);
            end
            if (i_Req_DV[w_sum[c_IDX_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_sum[c_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_issue_idx = (r_state == S_HOLD) ? r_gidx : w_win_idx;
        w_g_next    = (r_gidx == c_LAST_IDX) ? '0 : r_gidx + c_IDX_W'(1);
        w_cnt_inc   = (r_cnt == c_CNT_SAT) ? r_cnt : r_cnt + c_CNT_W'(1);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gidx_nxt    = r_gidx;
        w_grant_nxt   = r_grant;
        w_rr_nxt      = r_rr;
        w_cnt_nxt     = r_cnt;
        w_last_nxt    = r_last;
        w_ack_nxt     = '0;
        w_tx_dv_nxt   = 1'b0;
        w_tx_byte_nxt = r_tx_byte;
        w_err_nxt     = 1'b0;
        w_busy_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // uart_tx has no reset, so never start while it is still finishing.
                if (!i_Tx_Active && !i_Tx_Done && w_win_found) begin
                    w_state_nxt   = S_ISSUE;
                    w_gidx_nxt    = w_issue_idx;
                    w_grant_nxt   = c_ONE_HOT0 << w_issue_idx;
                    w_ack_nxt     = c_ONE_HOT0 << w_issue_idx;
                    w_tx_dv_nxt   = 1'b1;
                    w_tx_byte_nxt = i_Req_Byte[{w_issue_idx, 3'b000} +: 8];
                end
            end
            S_ISSUE: begin
                w_last_nxt  = i_Req_Last[r_gidx];
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_cnt_inc == c_WDOG_CNT) begin
                    w_err_nxt   = 1'b1;
                    w_grant_nxt = '0;
                    w_rr_nxt    = w_g_next;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_DRAIN: begin
                if (!i_Tx_Done && !i_Tx_Active) begin
                    if (r_last) begin
                        w_grant_nxt = '0;
                        w_rr_nxt    = w_g_next;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (i_Req_DV[r_gidx]) begin
                    w_state_nxt   = S_ISSUE;
                    w_ack_nxt     = c_ONE_HOT0 << w_issue_idx;
                    w_tx_dv_nxt   = 1'b1;
                    w_tx_byte_nxt = i_Req_Byte[{w_issue_idx, 3'b000} +: 8];
                end else if (w_cnt_inc == c_HOLD_CNT) begin
                    w_err_nxt   = 1'b1;
                    w_grant_nxt = '0;
                    w_rr_nxt    = w_g_next;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_state   <= S_IDLE;
            r_gidx    <= '0;
            r_grant   <= '0;
            r_rr      <= '0;
            r_cnt     <= '0;
            r_last    <= 1'b0;
            r_ack     <= '0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gidx    <= w_gidx_nxt;
            r_grant   <= w_grant_nxt;
            r_rr      <= w_rr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
            r_ack     <= w_ack_nxt;
            r_tx_dv   <= w_tx_dv_nxt;
            r_tx_byte <= w_tx_byte_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign o_Req_Ack     = r_ack;
    assign o_Grant       = r_grant;
    assign o_Busy        = r_busy;
    assign o_Err_Timeout = r_err;
    assign o_Tx_DV       = r_tx_dv;
    assign o_Tx_Byte     = r_tx_byte;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed bench for uart_tx_arbiter with a behavioural uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int CLKS_PER_BIT = 4;
    localparam int HOLD_CLKS    = 30;
    localparam int WDOG         = 12 * CLKS_PER_BIT;
    localparam int FRAME        = 10 * CLKS_PER_BIT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_dv;
    logic [8*NUM_REQ-1:0] req_byte;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 err;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 tx_active;
    logic                 tx_done;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .HOLD_CLKS    (HOLD_CLKS)
    ) dut (
        .i_Clock       (clk),
        .i_Rst_n       (rst_n),
        .i_Req_DV      (req_dv),
        .i_Req_Byte    (req_byte),
        .i_Req_Last    (req_last),
        .o_Req_Ack     (ack),
        .o_Grant       (grant),
        .o_Busy        (busy),
        .o_Err_Timeout (err),
        .o_Tx_DV       (tx_dv),
        .o_Tx_Byte     (tx_byte),
        .i_Tx_Active   (tx_active),
        .i_Tx_Done     (tx_done)
    );

    // Behavioural uart_tx: Active for one frame, then Done for 2 clocks; no reset.
    int         cyc           = 0;
    int         m_phase       = 0;
    int         m_cnt         = 0;
    int         done_fall_cyc = 0;
    logic       model_en      = 1'b1;
    logic       overlap_seen  = 1'b0;
    logic [7:0] sent_q[$];

    assign tx_active = (m_phase == 1);
    assign tx_done   = (m_phase == 2);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        case (m_phase)
            0: if (tx_dv && model_en) begin
                sent_q.push_back(tx_byte);
                m_phase <= 1;
                m_cnt   <= 1;
            end
            1: begin
                if (tx_dv) overlap_seen <= 1'b1;
                if (m_cnt == FRAME) begin
                    m_phase <= 2;
                    m_cnt   <= 1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
            default: begin
                if (tx_dv) overlap_seen <= 1'b1;
                if (m_cnt == 2) begin
                    m_phase       <= 0;
                    done_fall_cyc <= cyc;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        endcase
    end

    // Requester byte queues: {last, byte}
    logic [8:0]         rq_mem [NUM_REQ][8];
    int                 rq_head [NUM_REQ];
    int                 rq_tail [NUM_REQ];
    logic [NUM_REQ-1:0] ack_pend  = '0;
    logic [NUM_REQ-1:0] prev_ack  = '0;
    logic               prev_err  = 1'b0;
    logic               dbl_pulse = 1'b0;
    int                 err_cnt   = 0;
    int                 err_cyc   = 0;
    int                 err_ref   = 0;
    int                 dv_cyc    = 0;
    int                 n_checks  = 0;
    int                 n_fail    = 0;

    task automatic clear_q();
        for (int r = 0; r < NUM_REQ; r++) begin
            rq_head[r] = 0;
            rq_tail[r] = 0;
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic last);
        rq_mem[r][rq_tail[r]] = {last, b};
        rq_tail[r]++;
    endtask

    function automatic bit q_empty();
        for (int r = 0; r < NUM_REQ; r++)
            if (rq_head[r] < rq_tail[r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int r = 0; r < NUM_REQ; r++) begin
            if (rq_head[r] < rq_tail[r]) begin
                req_dv[r]         = 1'b1;
                req_byte[8*r +: 8] = rq_mem[r][rq_head[r]][7:0];
                req_last[r]       = rq_mem[r][rq_head[r]][8];
            end else begin
                req_dv[r]         = 1'b0;
                req_byte[8*r +: 8] = 8'h00;
                req_last[r]       = 1'b0;
            end
        end
    endtask

    // Requesters release a byte the cycle after seeing its Ack, keeping Last stable through ISSUE.
    task automatic step();
        @(negedge clk);
        for (int r = 0; r < NUM_REQ; r++)
            if (ack_pend[r] && rq_head[r] < rq_tail[r]) rq_head[r]++;
        ack_pend = ack;
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
            err_ref = done_fall_cyc;
            if (prev_err) dbl_pulse = 1'b1;
        end
        if ((ack & prev_ack) != '0) dbl_pulse = 1'b1;
        prev_err = err;
        prev_ack = ack;
        if (tx_dv) dv_cyc = cyc;
        drive();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (q_empty() && !busy && m_phase == 0 && ack_pend == '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_err(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (err) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_q();
        drive();
        repeat (3) step();
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        n_checks++; if ({busy, err, tx_dv} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got busy/err/dv=%b expected 000", {busy, err, tx_dv}); end
        n_checks++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h expected 00", tx_byte); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        bit ok;
        int base;
        base = sent_q.size();
        push(0, 8'h41, 1'b1);
        drive();
        step();
        n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b expected 0001", ack); end
        n_checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'h41) begin n_fail++; $display("FAIL single_issue: got dv=%b byte=%h expected dv=1 byte=41", tx_dv, tx_byte); end
        n_checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin n_fail++; $display("FAIL single_grant: got grant=%b busy=%b expected 0001/1", grant, busy); end
        step();
        n_checks++; if (tx_dv !== 1'b0 || ack !== 4'b0000) begin n_fail++; $display("FAIL single_pulse: got dv=%b ack=%b expected 0/0000", tx_dv, ack); end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!busy) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_busy_drop: got busy=1 expected 0 within 200 clocks"); end
        n_checks++; if (m_phase != 0) begin n_fail++; $display("FAIL single_drop_time: got uart phase %0d expected 0 when Busy falls", m_phase); end
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_release: got %b expected 0000", grant); end
        n_checks++; if (sent_q.size() != base + 1 || sent_q[base] !== 8'h41) begin n_fail++; $display("FAIL single_wire: got %0d bytes expected one byte 41", sent_q.size() - base); end
    endtask

    task automatic test_contention();
        bit         ok;
        int         base;
        logic [7:0] exp_b;
        // Restart from reset so the rr pointer is at 0.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        clear_q();
        base = sent_q.size();
        for (int round = 0; round < 2; round++) begin
            for (int r = 0; r < NUM_REQ; r++) push(r, 8'hA0 + 8'(r) + 8'(16 * round), 1'b1);
            drive();
            wait_idle(1500, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL contention_done: round %0d did not drain", round); end
        end
        n_checks++; if (sent_q.size() != base + 8) begin n_fail++; $display("FAIL contention_count: got %0d expected 8", sent_q.size() - base); end
        for (int k = 0; k < 8 && base + k < sent_q.size(); k++) begin
            exp_b = 8'hA0 + 8'(k % 4) + 8'(16 * (k / 4));
            n_checks++; if (sent_q[base+k] !== exp_b) begin n_fail++; $display("FAIL contention_order[%0d]: got %h expected %h", k, sent_q[base+k], exp_b); end
        end
        n_checks++; if (overlap_seen !== 1'b0) begin n_fail++; $display("FAIL contention_overlap: got 1 expected 0"); end
    endtask

    task automatic test_locking();
        bit         ok;
        int         base;
        logic [7:0] exp_b [4];
        exp_b = '{8'h4F, 8'h4B, 8'h0A, 8'h55};
        clear_q();
        base = sent_q.size();
        push(1, 8'h4F, 1'b0);
        push(1, 8'h4B, 1'b0);
        push(1, 8'h0A, 1'b1);
        push(2, 8'h55, 1'b1);
        drive();
        wait_idle(1500, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL lock_done: did not drain"); end
        n_checks++; if (sent_q.size() != base + 4) begin n_fail++; $display("FAIL lock_count: got %0d expected 4", sent_q.size() - base); end
        for (int k = 0; k < 4 && base + k < sent_q.size(); k++) begin
            n_checks++; if (sent_q[base+k] !== exp_b[k]) begin n_fail++; $display("FAIL lock_order[%0d]: got %h expected %h", k, sent_q[base+k], exp_b[k]); end
        end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL lock_no_err: got %0d timeouts expected 0", err_cnt); end
    endtask

    task automatic test_hold_timeout();
        bit ok;
        int base;
        clear_q();
        base = sent_q.size();
        push(0, 8'h11, 1'b0);
        push(1, 8'h22, 1'b1);
        drive();
        wait_err(500, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_err_seen: got no timeout expected one"); end
        // HOLD is entered one clock after Done falls; timeout after HOLD_CLKS clocks there.
        n_checks++; if (err_cyc - err_ref != HOLD_CLKS + 2) begin n_fail++; $display("FAIL hold_err_time: got %0d expected %0d", err_cyc - err_ref, HOLD_CLKS + 2); end
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL hold_release: got %b expected 0000", grant); end
        n_checks++; if (sent_q.size() != base + 1) begin n_fail++; $display("FAIL hold_no_steal: got %0d bytes expected 1 before timeout", sent_q.size() - base); end
        step();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL hold_err_pulse: got 1 expected 0"); end
        wait_idle(500, ok);
        n_checks++; if (!ok || sent_q.size() != base + 2 || sent_q[base+1] !== 8'h22) begin n_fail++; $display("FAIL hold_next: got %0d bytes expected 11 then 22", sent_q.size() - base); end
    endtask

    task automatic test_watchdog();
        bit ok;
        int e0;
        clear_q();
        e0 = err_cnt;
        model_en = 1'b0;
        push(2, 8'h33, 1'b1);
        drive();
        wait_err(200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wdog_err_seen: got no timeout expected one"); end
        // One ISSUE cycle then 12*CLKS_PER_BIT clocks in WAIT_DONE.
        n_checks++; if (err_cyc - dv_cyc != WDOG + 1) begin n_fail++; $display("FAIL wdog_err_time: got %0d expected %0d", err_cyc - dv_cyc, WDOG + 1); end
        n_checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL wdog_idle: got busy=%b grant=%b expected 0/0000", busy, grant); end
        step();
        n_checks++; if (err !== 1'b0 || err_cnt != e0 + 1) begin n_fail++; $display("FAIL wdog_err_pulse: got err=%b count=%0d expected 0/%0d", err, err_cnt, e0 + 1); end
        model_en = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base;
        clear_q();
        base = sent_q.size();
        push(1, 8'h61, 1'b1);
        drive();
        wait_idle(500, ok);
        push(0, 8'h70, 1'b1);
        drive();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (m_phase == 1) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_start: req0 byte never started"); end
        repeat (10) step();
        rst_n = 1'b0;
        step();
        n_checks++; if ({grant, ack} !== 8'h00) begin n_fail++; $display("FAIL rstmid_grant_ack: got %b/%b expected 0000/0000", grant, ack); end
        n_checks++; if ({busy, err, tx_dv} !== 3'b000 || tx_byte !== 8'h00) begin n_fail++; $display("FAIL rstmid_outputs: got flags=%b byte=%h expected 000/00", {busy, err, tx_dv}, tx_byte); end
        rst_n = 1'b1;
        push(3, 8'h73, 1'b1);
        push(1, 8'h71, 1'b1);
        drive();
        wait_idle(1500, ok);
        n_checks++; if (!ok || sent_q.size() != base + 4) begin n_fail++; $display("FAIL rstmid_count: got %0d bytes expected 4", sent_q.size() - base); end
        else begin
            n_checks++; if (sent_q[base+2] !== 8'h71 || sent_q[base+3] !== 8'h73) begin n_fail++; $display("FAIL rstmid_rr: got %h,%h expected 71,73", sent_q[base+2], sent_q[base+3]); end
        end
        n_checks++; if (overlap_seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_overlap: got 1 expected 0"); end
    endtask

    task automatic test_pulses();
        n_checks++; if (dbl_pulse !== 1'b0) begin n_fail++; $display("FAIL pulse_width: got a 2-cycle Ack/Err expected none"); end
        n_checks++; if (err_cnt != 2) begin n_fail++; $display("FAIL err_total: got %0d expected 2", err_cnt); end
    endtask

    initial begin
        rst_n    = 1'b0;
        req_dv   = '0;
        req_byte = '0;
        req_last = '0;
        test_reset();
        test_single();
        test_contention();
        test_locking();
        test_hold_timeout();
        test_watchdog();
        test_reset_mid();
        test_pulses();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
